// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: request payload and grant-source encoding.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_PIPE = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO of writeback requests; pointers wrap naturally, count has one extra bit.
module wb_sync_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_push,
  input  wb_req_t        i_data,
  input  logic           i_pop,
  output wb_req_t        o_head,
  output logic           o_full,
  output logic           o_empty,
  output logic [PTR_W:0] o_count
);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Overflow/underflow requests are dropped rather than corrupting state.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Owns the register-file write port, merging pipeline results with buffered long-latency results.
// Optional starvation guard for the buffered path: define WB_STARVE_GUARD_EN.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = WB_DATA_W,
  parameter int ADDR_WIDTH   = WB_ADDR_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  pipe_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] pipe_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] pipe_rd_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_rd_data_i,
  output logic                  pipe_stall_o,
  output logic                  wb_pending_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_wr_data_o,
  output logic                  rd_wr_en_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (DATA_WIDTH != WB_DATA_W || ADDR_WIDTH != WB_ADDR_W || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("wb_write_arbiter: unsupported parameter combination");
  end

  wb_req_t         w_lsu_req;
  wb_req_t         w_head;
  logic [CNT_W-1:0] w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_pipe_req;
  logic            w_stall;
  wb_src_e         w_src;

  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  assign lsu_ready_o  = (w_count < CNT_W'(FIFO_DEPTH));
  assign wb_pending_o = ~w_empty;
  assign pipe_stall_o = w_stall;
  assign rd_wr_en_o   = r_wr_en;
  assign rd_addr_o    = r_addr;
  assign rd_wr_data_o = r_data;

  // x0 beats still complete the handshake but never occupy a slot.
  assign w_lsu_req.addr = lsu_rd_addr_i;
  assign w_lsu_req.data = lsu_rd_data_i;
  assign w_push     = lsu_valid_i & ~w_full & (lsu_rd_addr_i != '0);
  assign w_pipe_req = pipe_wr_en_i & (pipe_rd_addr_i != '0) & ~w_stall;
  assign w_pop      = (w_src == WB_LSU);

  wb_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (resetn_i),
    .i_push  (w_push),
    .i_data  (w_lsu_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_src = WB_NONE;
    if (w_pipe_req)    w_src = WB_PIPE;
    else if (!w_empty) w_src = WB_LSU;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_wr_en <= (w_src != WB_NONE);
      case (w_src)
        WB_PIPE: begin
          r_addr <= pipe_rd_addr_i;
          r_data <= pipe_rd_data_i;
        end
        WB_LSU: begin
          r_addr <= w_head.addr;
          r_data <= w_head.data;
        end
        default: begin
          r_addr <= r_addr;
          r_data <= r_data;
        end
      endcase
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic [STARVE_W-1:0] w_starve_nxt;
  logic                r_stall;

  // Counts pipe wins over a waiting FIFO head; the stall lands the cycle after the limit is hit.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_empty || w_pop)
      w_starve_nxt = '0;
    else if (w_src == WB_PIPE && r_starve_cnt != STARVE_W'(STARVE_LIMIT))
      w_starve_nxt = r_starve_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_stall      <= ~r_stall & (w_starve_nxt == STARVE_W'(STARVE_LIMIT));
    end
  end

  assign w_stall = r_stall;
`else
  assign w_stall = 1'b0;
`endif

endmodule
